// File: rtl/alarm_ctrl.sv
// Vehicle alarm sequencer that drives an external countdown timer.
// Optional ALARM_STATUS_BLINK_EN: status LED blinks on the 1 Hz tick while arming/armed.
module alarm_ctrl #(
  localparam int unsigned TW = 4,
  parameter logic [TW-1:0] T_ARM       = 4'd6,
  parameter logic [TW-1:0] T_DRIVER    = 4'd8,
  parameter logic [TW-1:0] T_PASSENGER = 4'd15,
  parameter logic [TW-1:0] T_ALARM     = 4'd10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ignition,
  input  logic          door_driver,
  input  logic          door_pass,
  input  logic          reprogram,
  input  logic [1:0]    time_param_sel,
  input  logic [TW-1:0] time_value,
  input  logic          expired,
  input  logic          one_hz_enable,
  output logic          start_timer,
  output logic [TW-1:0] interval,
  output logic          siren,
  output logic          status
);

  localparam logic [1:0] SEL_ARM       = 2'd0;
  localparam logic [1:0] SEL_DRIVER    = 2'd1;
  localparam logic [1:0] SEL_PASSENGER = 2'd2;
  localparam logic [1:0] SEL_ALARM     = 2'd3;
  localparam logic [1:0] GUARD_CYCLES  = 2'd2;

  typedef enum logic [2:0] {
    DISARMED  = 3'd0,
    ARM_WAIT  = 3'd1,
    ARMED     = 3'd2,
    TRIGGERED = 3'd3,
    ALARM     = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] arm_reg;
  logic [TW-1:0] driver_reg;
  logic [TW-1:0] pass_reg;
  logic [TW-1:0] alarm_reg;
  logic [TW-1:0] wr_value;
  logic [1:0]    guard_cnt;
  logic          door_open;
  logic          expired_ok;
  logic          status_hold;

  assign door_open = door_driver | door_pass;

  // expired is stale while the timer is still reloading after a start pulse
  assign expired_ok = expired && (guard_cnt == 2'd0);

  // A zero delay would never expire cleanly, so it is stored as one second
  assign wr_value = (time_value == '0) ? TW'(1) : time_value;

`ifdef ALARM_STATUS_BLINK_EN
  assign status_hold = status ^ one_hz_enable;
`else
  logic unused_one_hz;
  assign unused_one_hz = one_hz_enable;
  assign status_hold   = 1'b1;
`endif

  // Programmable delay registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      arm_reg    <= T_ARM;
      driver_reg <= T_DRIVER;
      pass_reg   <= T_PASSENGER;
      alarm_reg  <= T_ALARM;
    end else if (reprogram) begin
      case (time_param_sel)
        SEL_ARM:       arm_reg    <= wr_value;
        SEL_DRIVER:    driver_reg <= wr_value;
        SEL_PASSENGER: pass_reg   <= wr_value;
        SEL_ALARM:     alarm_reg  <= wr_value;
        default:       arm_reg    <= wr_value;
      endcase
    end
  end

  // Alarm sequencer; every timer launch loads interval and re-arms the guard
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= DISARMED;
      start_timer <= 1'b0;
      interval    <= '0;
      siren       <= 1'b0;
      status      <= 1'b0;
      guard_cnt   <= '0;
    end else begin
      start_timer <= 1'b0;
      if (guard_cnt != 2'd0) guard_cnt <= guard_cnt - 2'd1;

      if (reprogram) begin
        state  <= DISARMED;
        siren  <= 1'b0;
        status <= 1'b0;
      end else begin
        case (state)
          DISARMED: begin
            if (!ignition && !door_open) begin
              state       <= ARM_WAIT;
              start_timer <= 1'b1;
              interval    <= arm_reg;
              guard_cnt   <= GUARD_CYCLES;
              status      <= 1'b1;
            end
          end

          ARM_WAIT: begin
            if (ignition || door_open) begin
              state  <= DISARMED;
              status <= 1'b0;
            end else if (expired_ok) begin
              state  <= ARMED;
              status <= 1'b1;
            end else begin
              status <= status_hold;
            end
          end

          ARMED: begin
            if (ignition) begin
              state  <= DISARMED;
              status <= 1'b0;
            end else if (door_driver) begin
              state       <= TRIGGERED;
              start_timer <= 1'b1;
              interval    <= driver_reg;
              guard_cnt   <= GUARD_CYCLES;
              status      <= 1'b1;
            end else if (door_pass) begin
              state       <= TRIGGERED;
              start_timer <= 1'b1;
              interval    <= pass_reg;
              guard_cnt   <= GUARD_CYCLES;
              status      <= 1'b1;
            end else begin
              status <= status_hold;
            end
          end

          TRIGGERED: begin
            if (ignition) begin
              state  <= DISARMED;
              status <= 1'b0;
            end else if (expired_ok) begin
              state       <= ALARM;
              start_timer <= 1'b1;
              interval    <= alarm_reg;
              guard_cnt   <= GUARD_CYCLES;
              siren       <= 1'b1;
            end
          end

          ALARM: begin
            if (ignition) begin
              state  <= DISARMED;
              siren  <= 1'b0;
              status <= 1'b0;
            end else if (expired_ok && door_open) begin
              start_timer <= 1'b1;
              interval    <= alarm_reg;
              guard_cnt   <= GUARD_CYCLES;
            end else if (expired_ok) begin
              state  <= ARMED;
              siren  <= 1'b0;
              status <= 1'b1;
            end
          end

          default: begin
            state  <= DISARMED;
            siren  <= 1'b0;
            status <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios then random traffic against a timestamp-based model.
module tb_alarm_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       ignition, door_driver, door_pass, reprogram, expired, one_hz_enable;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       start_timer, siren, status;
  logic [3:0] interval;

  int checks = 0;
  int errors = 0;

  alarm_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .ignition       (ignition),
    .door_driver    (door_driver),
    .door_pass      (door_pass),
    .reprogram      (reprogram),
    .time_param_sel (time_param_sel),
    .time_value     (time_value),
    .expired        (expired),
    .one_hz_enable  (one_hz_enable),
    .start_timer    (start_timer),
    .interval       (interval),
    .siren          (siren),
    .status         (status)
  );

  always #5 clock = ~clock;

  // Reference model: behaviour mode, delay table, and the edge at which the last timer was launched
  typedef enum int {M_OFF, M_WAIT, M_ARMED, M_TRIG, M_ALARM} mode_t;
  mode_t      m_mode;
  logic [3:0] m_delay [4];
  int         m_edge;
  int         m_pulse_edge;
  logic       m_start, m_siren, m_status;
  logic [3:0] m_interval;

  task automatic model_reset();
    m_mode       = M_OFF;
    m_delay[0]   = 4'd6;
    m_delay[1]   = 4'd8;
    m_delay[2]   = 4'd15;
    m_delay[3]   = 4'd10;
    m_pulse_edge = -1000;
    m_start      = 1'b0;
    m_interval   = 4'd0;
    m_siren      = 1'b0;
    m_status     = 1'b0;
  endtask

  task automatic launch(input int idx);
    m_start      = 1'b1;
    m_interval   = m_delay[idx];
    m_pulse_edge = m_edge;
  endtask

  task automatic model_edge();
    mode_t prev;
    logic  exp_ok;
    logic  any_door;
    m_edge++;
    prev     = m_mode;
    m_start  = 1'b0;
    // the pulse cycle and the one after it cannot report expiry
    exp_ok   = expired && (m_edge >= m_pulse_edge + 3);
    any_door = door_driver || door_pass;
    if (reprogram) begin
      m_delay[time_param_sel] = (time_value == 4'd0) ? 4'd1 : time_value;
      m_mode = M_OFF;
    end else begin
      case (m_mode)
        M_OFF:   if (!ignition && !any_door) begin m_mode = M_WAIT; launch(0); end
        M_WAIT:  if (ignition || any_door) m_mode = M_OFF;
                 else if (exp_ok) m_mode = M_ARMED;
        M_ARMED: if (ignition) m_mode = M_OFF;
                 else if (door_driver) begin m_mode = M_TRIG; launch(1); end
                 else if (door_pass) begin m_mode = M_TRIG; launch(2); end
        M_TRIG:  if (ignition) m_mode = M_OFF;
                 else if (exp_ok) begin m_mode = M_ALARM; launch(3); end
        M_ALARM: if (ignition) m_mode = M_OFF;
                 else if (exp_ok && any_door) launch(3);
                 else if (exp_ok) m_mode = M_ARMED;
        default: m_mode = M_OFF;
      endcase
    end
    m_siren = (m_mode == M_ALARM);
    if (m_mode == M_OFF) m_status = 1'b0;
    else if (m_mode == M_TRIG || m_mode == M_ALARM) m_status = 1'b1;
    else if (m_mode != prev) m_status = 1'b1;
`ifdef ALARM_STATUS_BLINK_EN
    else if (one_hz_enable) m_status = ~m_status;
`else
    else m_status = 1'b1;
`endif
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_model();
    chk("start_timer", 4'(start_timer), 4'(m_start));
    chk("interval",    interval,        m_interval);
    chk("siren",       4'(siren),       4'(m_siren));
    chk("status",      4'(status),      4'(m_status));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_model();
  endtask

  task automatic drive(input logic ign, input logic drv, input logic pas, input logic exp);
    ignition    = ign;
    door_driver = drv;
    door_pass   = pas;
    expired     = exp;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0);
    reprogram = 0; time_param_sel = 2'd0; time_value = 4'd0; one_hz_enable = 0;
    m_edge = 0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_start", 4'(start_timer), 4'd0);
    chk("rst_interval", interval, 4'd0);
    chk("rst_siren", 4'(siren), 4'd0);
    chk("rst_status", 4'(status), 4'd0);

    // Arm with expired held through the pulse and guard cycle
    reset = 1'b0;
    drive(0, 0, 0, 1);
    step();
    chk("arm_pulse", 4'(start_timer), 4'd1);
    chk("arm_interval", interval, 4'd6);
    step();
    chk("arm_pulse_1cyc", 4'(start_timer), 4'd0);
    chk("arm_interval_held", interval, 4'd6);
    step(); step();

    // Passenger trigger, then alarm once the guard has passed
    drive(0, 0, 1, 0); step();
    chk("pass_pulse", 4'(start_timer), 4'd1);
    chk("pass_interval", interval, 4'd15);
    drive(0, 0, 0, 1); step();
    chk("trig_guard0", 4'(siren), 4'd0);
    step();
    chk("trig_guard1", 4'(siren), 4'd0);
    step();
    chk("alarm_siren", 4'(siren), 4'd1);
    chk("alarm_pulse", 4'(start_timer), 4'd1);
    chk("alarm_interval", interval, 4'd10);

    // Alarm expiry with doors closed returns to armed without a pulse
    step(); step(); step();
    chk("rearm_siren", 4'(siren), 4'd0);
    chk("rearm_nopulse", 4'(start_timer), 4'd0);
    chk("rearm_status", 4'(status), 4'd1);

    // Driver trigger, alarm, then restart while a door stays open
    drive(0, 1, 0, 0); step();
    chk("drv_interval", interval, 4'd8);
    drive(0, 1, 0, 1); step(); step(); step();
    chk("alarm2_siren", 4'(siren), 4'd1);
    step(); step(); step();
    chk("restart_pulse", 4'(start_timer), 4'd1);
    chk("restart_interval", interval, 4'd10);
    chk("restart_siren", 4'(siren), 4'd1);

    // Reprogram driver delay with zero; running interval untouched
    drive(0, 0, 0, 0);
    reprogram = 1; time_param_sel = 2'd1; time_value = 4'd0;
    step();
    reprogram = 0;
    chk("reprog_status", 4'(status), 4'd0);
    chk("reprog_siren", 4'(siren), 4'd0);
    chk("reprog_nopulse", 4'(start_timer), 4'd0);
    chk("reprog_interval_kept", interval, 4'd10);
    step();
    drive(0, 0, 0, 1); step(); step(); step();
    drive(0, 1, 0, 0); step();
    chk("drv_one_sec", interval, 4'd1);

    // Ignition while triggered disarms
    drive(1, 0, 0, 0); step();
    chk("ign_disarm_status", 4'(status), 4'd0);

    // Reprogram together with ignition
    reprogram = 1; time_param_sel = 2'd0; time_value = 4'd3;
    step();
    reprogram = 0;
    chk("reprog_ign_status", 4'(status), 4'd0);
    drive(0, 0, 0, 0); step();
    chk("new_arm_interval", interval, 4'd3);

    // Reach ALARM and reset asynchronously mid-cycle
    drive(0, 0, 0, 1); step(); step(); step();
    drive(0, 0, 1, 0); step();
    drive(0, 0, 0, 1); step(); step(); step();
    chk("pre_reset_siren", 4'(siren), 4'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_siren", 4'(siren), 4'd0);
    chk("async_interval", interval, 4'd0);
    chk("async_status", 4'(status), 4'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(1, 0, 0, 1); step();
    chk("post_reset_nopulse", 4'(start_timer), 4'd0);
    drive(0, 0, 0, 0); step();
    chk("post_reset_arm", interval, 4'd6);

    // Random traffic against the model
    for (int i = 0; i < 2500; i++) begin
      ignition      = ($urandom_range(99) < 6);
      door_driver   = ($urandom_range(99) < 10);
      door_pass     = ($urandom_range(99) < 10);
      expired       = ($urandom_range(99) < 45);
      one_hz_enable = ($urandom_range(99) < 20);
      reprogram     = ($urandom_range(99) < 3);
      time_param_sel = 2'($urandom_range(3));
      time_value     = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
